rc4_search_scheduler: RTL and testbench

Top-level sequencer for the RC4 key-search datapath. It drives the three phase engines (S-memory init, key-scheduling shuffle, decrypt/validate) through start/done handshakes and arbitrates the single-port S memory between them. It owns the candidate-key counter: it advances the key when decrypt reports an invalid character, and it stops on success or when the key space is exhausted.

---
 rtl/rc4_search_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_rc4_search_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_search_scheduler.sv
// rc4_search_scheduler
// Top-level sequencer for the RC4 key-search datapath. Runs the three phase
// engines (S init, key-scheduling shuffle, decrypt/validate) in order through
// one-cycle start/done handshakes, owns the candidate-key counter and steers
// the single-port S memory to whichever engine currently owns it.
//
// Optional build feature: define RC4_SCHED_WATCHDOG_EN to add a per-phase
// timeout (WDOG_CYCLES) that parks the search in ERROR when an engine never
// reports done. Without it, WAIT states wait indefinitely and error stays 0.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start, abort                  one-cycle control pulses
//   init/ksa/dec_start            one-cycle engine start pulses (out)
//   init/ksa/dec_done, dec_fail   engine completion pulses, decrypt verdict
//   init/ksa/dec_addr/data/wren   per-engine S-memory requests
//   s_addr, s_data, s_wren        S-memory port, muxed by phase
//   secret_key                    current candidate key
//   busy                          search in progress
//   found, exhausted, error       sticky terminal status
module rc4_search_scheduler #(
  parameter int unsigned          KEY_WIDTH   = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX     = 24'h3FFFFF,
  parameter int unsigned          WDOG_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 init_start,
  output logic                 ksa_start,
  output logic                 dec_start,
  input  logic                 init_done,
  input  logic                 ksa_done,
  input  logic                 dec_done,
  input  logic                 dec_fail,
  input  logic [7:0]           init_addr,
  input  logic [7:0]           ksa_addr,
  input  logic [7:0]           dec_addr,
  input  logic [7:0]           init_data,
  input  logic [7:0]           ksa_data,
  input  logic [7:0]           dec_data,
  input  logic                 init_wren,
  input  logic                 ksa_wren,
  input  logic                 dec_wren,
  output logic [7:0]           s_addr,
  output logic [7:0]           s_data,
  output logic                 s_wren,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic                 error
);

  typedef enum logic [3:0] {
    IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, DEC_GO, DEC_WAIT,
    NEXT_KEY, FOUND, EXHAUSTED, ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 found_q, found_d;
  logic                 exhausted_q, exhausted_d;
  logic                 error_q, error_d;
  logic                 idle_like;
  logic                 wdog_expired;

`ifdef RC4_SCHED_WATCHDOG_EN
  logic [15:0] wdog_q, wdog_d;

  // Counter is 0 in the first WAIT cycle, so expiry lands on the edge where
  // it would reach WDOG_CYCLES.
  assign wdog_expired = (wdog_q == 16'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if (state_q inside {INIT_WAIT, KSA_WAIT, DEC_WAIT}) wdog_d = wdog_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`else
  // No watchdog: the timeout can never fire.
  assign wdog_expired = 1'b0 & (WDOG_CYCLES == 0);
`endif

  // Non-busy states are the only ones that accept start.
  assign idle_like = (state_q inside {IDLE, FOUND, EXHAUSTED, ERROR});

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    error_d     = error_q;

    if (idle_like) begin
      if (start) begin
        key_d       = '0;
        found_d     = 1'b0;
        exhausted_d = 1'b0;
        error_d     = 1'b0;
        state_d     = INIT_GO;
      end
    end else if (abort) begin
      // Abort beats any done pulse arriving in the same cycle.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        INIT_GO: state_d = INIT_WAIT;
        INIT_WAIT: begin
          if (init_done)         state_d = KSA_GO;
          else if (wdog_expired) begin state_d = ERROR; error_d = 1'b1; end
        end
        KSA_GO: state_d = KSA_WAIT;
        KSA_WAIT: begin
          if (ksa_done)          state_d = DEC_GO;
          else if (wdog_expired) begin state_d = ERROR; error_d = 1'b1; end
        end
        DEC_GO: state_d = DEC_WAIT;
        DEC_WAIT: begin
          if (dec_done) begin
            if (dec_fail) state_d = NEXT_KEY;
            else begin state_d = FOUND; found_d = 1'b1; end
          end else if (wdog_expired) begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
        NEXT_KEY: begin
          // KEY_MAX stops the search before the counter could wrap.
          if (key_q == KEY_MAX) begin
            state_d     = EXHAUSTED;
            exhausted_d = 1'b1;
          end else begin
            key_d   = key_q + 1'b1;
            state_d = INIT_GO;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      error_q     <= error_d;
    end
  end

  // S-memory ownership follows the phase; the mux adds no register stage.
  always_comb begin
    s_addr = 8'h00;
    s_data = 8'h00;
    s_wren = 1'b0;
    unique case (state_q)
      INIT_GO, INIT_WAIT: begin s_addr = init_addr; s_data = init_data; s_wren = init_wren; end
      KSA_GO,  KSA_WAIT:  begin s_addr = ksa_addr;  s_data = ksa_data;  s_wren = ksa_wren;  end
      DEC_GO,  DEC_WAIT:  begin s_addr = dec_addr;  s_data = dec_data;  s_wren = dec_wren;  end
      default: ;
    endcase
  end

  assign init_start = (state_q == INIT_GO);
  assign ksa_start  = (state_q == KSA_GO);
  assign dec_start  = (state_q == DEC_GO);
  assign busy       = !idle_like;
  assign secret_key = key_q;
  assign found      = found_q;
  assign exhausted  = exhausted_q;
  assign error      = error_q;

endmodule

// File: tb/tb_rc4_search_scheduler.sv
// Directed bench for rc4_search_scheduler. Two instances share all inputs:
// "dut" keeps the default key space, "dut_x" ends at KEY_MAX=3 for the
// exhaustion case. A simple engine model answers the start pulses of the
// selected instance with a done pulse LAT cycles later.
module tb_rc4_search_scheduler;

  localparam int LAT = 10;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic init_done = 1'b0, ksa_done = 1'b0, dec_done = 1'b0, dec_fail = 1'b0;
  logic [7:0] init_addr = 8'h11, ksa_addr = 8'h22, dec_addr = 8'h33;
  logic [7:0] init_data = 8'hA1, ksa_data = 8'hB2, dec_data = 8'hC3;
  logic init_wren = 1'b1, ksa_wren = 1'b1, dec_wren = 1'b1;

  logic init_start, ksa_start, dec_start, s_wren, busy, found, exhausted, error;
  logic [7:0] s_addr, s_data;
  logic [23:0] secret_key;
  logic x_init_start, x_ksa_start, x_dec_start, x_s_wren, x_busy, x_found, x_exhausted, x_error;
  logic [7:0] x_s_addr, x_s_data;
  logic [23:0] x_secret_key;

  int checks = 0, errors = 0;
  logic sel = 1'b0, ksa_hang = 1'b0, mon_en = 1'b0;
  logic [23:0] pass_key = 24'hFFFFFF;
  int n_init = 0, n_ksa = 0, n_dec = 0;

  rc4_search_scheduler #(.KEY_WIDTH(24), .KEY_MAX(24'h3FFFFF), .WDOG_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .init_start(init_start), .ksa_start(ksa_start), .dec_start(dec_start),
    .init_done(init_done), .ksa_done(ksa_done), .dec_done(dec_done), .dec_fail(dec_fail),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .dec_addr(dec_addr),
    .init_data(init_data), .ksa_data(ksa_data), .dec_data(dec_data),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren), .secret_key(secret_key),
    .busy(busy), .found(found), .exhausted(exhausted), .error(error));

  rc4_search_scheduler #(.KEY_WIDTH(24), .KEY_MAX(24'd3), .WDOG_CYCLES(16)) dut_x (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .init_start(x_init_start), .ksa_start(x_ksa_start), .dec_start(x_dec_start),
    .init_done(init_done), .ksa_done(ksa_done), .dec_done(dec_done), .dec_fail(dec_fail),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .dec_addr(dec_addr),
    .init_data(init_data), .ksa_data(ksa_data), .dec_data(dec_data),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .dec_wren(dec_wren),
    .s_addr(x_s_addr), .s_data(x_s_data), .s_wren(x_s_wren), .secret_key(x_secret_key),
    .busy(x_busy), .found(x_found), .exhausted(x_exhausted), .error(x_error));

  logic sel_init_start, sel_ksa_start, sel_dec_start, sel_busy;
  logic [23:0] sel_key;
  assign sel_init_start = sel ? x_init_start : init_start;
  assign sel_ksa_start  = sel ? x_ksa_start  : ksa_start;
  assign sel_dec_start  = sel ? x_dec_start  : dec_start;
  assign sel_busy       = sel ? x_busy       : busy;
  assign sel_key        = sel ? x_secret_key : secret_key;

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Engine model: inputs change at +1 after each rising edge.
  int init_cnt = 0, ksa_cnt = 0, dec_cnt = 0;
  initial forever begin
    @(posedge clk); #1;
    init_done = 1'b0; ksa_done = 1'b0; dec_done = 1'b0;
    if (init_cnt > 0) begin init_cnt--; if (init_cnt == 0) init_done = 1'b1; end
    if (ksa_cnt > 0)  begin ksa_cnt--;  if (ksa_cnt == 0 && !ksa_hang) ksa_done = 1'b1; end
    if (dec_cnt > 0) begin
      dec_cnt--;
      if (dec_cnt == 0) begin dec_done = 1'b1; dec_fail = (sel_key < pass_key); end
    end
    if (sel_init_start) init_cnt = LAT;
    if (sel_ksa_start)  ksa_cnt  = LAT;
    if (sel_dec_start)  dec_cnt  = LAT;
  end

  // Pulse counters and S-mux monitor at +2 after each rising edge.
  logic prev_init = 1'b0, prev_ksa = 1'b0, prev_dec = 1'b0, prev_fail = 1'b0;
  initial forever begin
    @(posedge clk); #2;
    if (sel_init_start) n_init++;
    if (sel_ksa_start)  n_ksa++;
    if (sel_dec_start)  n_dec++;
    if (mon_en) begin
      if (init_start || prev_init) begin
        check("mux_init_addr", s_addr, 8'h11); check("mux_init_data", s_data, 8'hA1);
        check("mux_init_wren", s_wren, 1);
      end
      if (ksa_start || prev_ksa) begin
        check("mux_ksa_addr", s_addr, 8'h22); check("mux_ksa_data", s_data, 8'hB2);
      end
      if (dec_start || prev_dec) begin
        check("mux_dec_addr", s_addr, 8'h33); check("mux_dec_data", s_data, 8'hC3);
      end
      if (prev_fail) begin
        check("mux_next_addr", s_addr, 8'h00); check("mux_next_wren", s_wren, 0);
      end
    end
    prev_init = init_start; prev_ksa = ksa_start; prev_dec = dec_start;
    prev_fail = dec_done && dec_fail;
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (sel_busy && n < budget) begin tick(); n++; end
    check({tag, "_timeout"}, sel_busy, 0);
  endtask

  // Returns both instances to a quiet non-busy state and lets stale done
  // pulses drain before the next scenario.
  task automatic idle_all();
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (LAT + 5) tick();
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_busy", busy, 0); check("rst_key", secret_key, 0);
    check("rst_starts", {init_start, ksa_start, dec_start}, 0);
    check("rst_s_addr", s_addr, 0); check("rst_s_wren", s_wren, 0);
    check("rst_flags", {found, exhausted, error}, 0);
    reset_n = 1'b1;
    tick();

    // Key found at key 3, with S-mux monitoring
    sel = 1'b0; pass_key = 24'd3; mon_en = 1'b1;
    n_init = 0; n_ksa = 0; n_dec = 0;
    do_start();
    check("go_init_start", init_start, 1); check("go_busy", busy, 1); check("go_key", secret_key, 0);
    tick();
    check("go_init_start_once", init_start, 0);
    wait_idle(1000, "found");
    mon_en = 1'b0;
    check("found_flag", found, 1); check("found_key", secret_key, 3);
    check("found_other_flags", {exhausted, error}, 0);
    check("found_n_init", n_init, 4); check("found_n_ksa", n_ksa, 4); check("found_n_dec", n_dec, 4);
    check("found_s_wren", s_wren, 0); check("found_s_addr", s_addr, 0);

    // Abort racing ksa_done at key 5
    pass_key = 24'hFFFFFF;
    do_start();
    check("restart_key", secret_key, 0); check("restart_found_clr", found, 0);
    begin
      int n = 0;
      while (!(secret_key == 24'd5 && ksa_done) && n < 2000) begin tick(); n++; end
      check("abort_reach_key5", n < 2000, 1);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 0); check("abort_key", secret_key, 5);
    check("abort_flags", {found, exhausted, error}, 0);
    n_ksa = 0;
    repeat (30) tick();
    check("abort_no_ksa_start", n_ksa, 0); check("abort_stays_idle", busy, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle_ignored", busy, 0);
    do_start();
    check("abort_restart_init", init_start, 1); check("abort_restart_key", secret_key, 0);

    // Asynchronous reset in DEC_WAIT, between clock edges
    begin
      int n = 0;
      while (!dec_start && n < 200) begin tick(); n++; end
      check("areset_reach_dec", dec_start, 1);
    end
    repeat (3) tick();
    reset_n = 1'b0; #1;
    check("areset_busy", busy, 0); check("areset_key", secret_key, 0);
    check("areset_starts", {init_start, ksa_start, dec_start}, 0);
    check("areset_s_bus", {s_addr, s_data, 7'd0, s_wren}, 0);
    check("areset_flags", {found, exhausted, error}, 0);
    #1 reset_n = 1'b1;
    repeat (LAT + 5) tick();
    check("areset_still_idle", busy, 0);
    do_start();
    check("areset_restart_init", init_start, 1); check("areset_restart_busy", busy, 1);

    // Exhaustion on the KEY_MAX=3 instance
    idle_all();
    sel = 1'b1; pass_key = 24'hFFFFFF;
    n_init = 0;
    do_start();
    wait_idle(1000, "exh");
    check("exh_flag", x_exhausted, 1); check("exh_found", x_found, 0);
    check("exh_key", x_secret_key, 3); check("exh_n_init", n_init, 4);
    repeat (30) tick();
    check("exh_no_5th_init", n_init, 4); check("exh_sticky", x_exhausted, 1);
    check("exh_error", x_error, 0);

`ifdef RC4_SCHED_WATCHDOG_EN
    // Watchdog: ksa never finishes
    idle_all();
    sel = 1'b0; ksa_hang = 1'b1;
    do_start();
    begin
      int n = 0;
      while (!ksa_start && n < 100) begin tick(); n++; end
      check("wdog_reach_ksa", ksa_start, 1);
    end
    repeat (16) tick();
    check("wdog_err_not_yet", error, 0); check("wdog_busy_before", busy, 1);
    tick();
    check("wdog_error", error, 1); check("wdog_busy", busy, 0);
    ksa_hang = 1'b0;
    do_start();
    check("wdog_error_cleared", error, 0); check("wdog_restart", init_start, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
